// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and FSM encoding for the fetch stage
// Contents: default widths, reset PC, NOP encoding, fetch FSM state type.
package fetch_unit_pkg;

  localparam int          FETCH_ADDR_W   = 32;
  localparam int          FETCH_INSN_W   = 32;
  localparam logic [31:0] FETCH_PC_RESET = 32'h80020000;
  localparam logic [31:0] NOP_INSN       = 32'h0;

  // S_IDLE: post-reset, no request
  // S_REQ : request on the bus, waiting for imem_ready
  // S_FULL: skid buffer holds a fetched instruction, bus idle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry {insn, pc} holding register for the fetch stage
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   push, pop, clear    : load entry / drain entry / discard entry (clear > push > pop)
//   push_insn, push_pc  : entry contents written on push
//   full                : entry holds a valid instruction
//   buf_insn, buf_pc    : stored entry
module fetch_skid_buffer
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int INSN_W = FETCH_INSN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [INSN_W-1:0] push_insn,
  input  logic [ADDR_W-1:0] push_pc,
  output logic              full,
  output logic [INSN_W-1:0] buf_insn,
  output logic [ADDR_W-1:0] buf_pc
);

  always_ff @(posedge clock) begin
    if (reset) begin
      full     <= 1'b0;
      buf_insn <= '0;
      buf_pc   <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full     <= 1'b1;
      buf_insn <= push_insn;
      buf_pc   <= push_pc;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC owner, imem handshake, IF/ID register
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   stall                        : hold IF/ID
//   branch_taken, branch_target  : EX-stage redirect
//   imem_req, imem_addr          : fetch request (held until imem_ready)
//   imem_ready, imem_rdata       : request accepted, instruction returned
//   insn_out, pc_out, valid_out  : IF/ID pipeline register
//   flush_out                    : one-cycle squash pulse to ID
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSN_W   = FETCH_INSN_W,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(FETCH_PC_RESET)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic [INSN_W-1:0] insn_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              valid_out,
  output logic              flush_out
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              kill;
  logic [ADDR_W-1:0] kill_addr;

  logic              accept;
  logic              fresh;
  logic              load_direct;
  logic              buf_push;
  logic              buf_pop;
  logic              buf_full;
  logic [INSN_W-1:0] buf_insn;
  logic [ADDR_W-1:0] buf_pc;

  // While a killed request is outstanding, pc already holds the redirect
  // target; the bus must keep presenting the original address until ready.
  assign imem_req  = (state == S_REQ);
  assign imem_addr = kill ? kill_addr : pc;

  assign accept      = (state == S_REQ) && imem_ready;
  // A returned word is a real instruction only if it is neither a stale
  // in-flight response nor arriving in the same cycle as a redirect.
  assign fresh       = accept && !kill && !branch_taken;
  assign load_direct = fresh && !stall && !buf_full;
  assign buf_push    = fresh && !load_direct;
  assign buf_pop     = buf_full && !stall && !branch_taken;

  fetch_skid_buffer #(
    .ADDR_W (ADDR_W),
    .INSN_W (INSN_W)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (buf_push),
    .pop       (buf_pop),
    .clear     (branch_taken),
    .push_insn (imem_rdata),
    .push_pc   (imem_addr),
    .full      (buf_full),
    .buf_insn  (buf_insn),
    .buf_pc    (buf_pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (buf_push) begin
          state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (branch_taken || !stall) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC and kill tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      pc        <= PC_RESET;
      kill      <= 1'b0;
      kill_addr <= PC_RESET;
    end else if (branch_taken) begin
      pc <= {branch_target[ADDR_W-1:2], 2'b00};
      if ((state == S_REQ) && !imem_ready) begin
        kill <= 1'b1;
        // On back-to-back redirects the bus still owes the first address.
        if (!kill) begin
          kill_addr <= pc;
        end
      end else begin
        kill <= 1'b0;
      end
    end else if (accept) begin
      if (kill) begin
        kill <= 1'b0;
      end else begin
        pc <= pc + ADDR_W'(4);
      end
    end
  end

  // IF/ID register
  always_ff @(posedge clock) begin
    if (reset) begin
      insn_out  <= INSN_W'(NOP_INSN);
      pc_out    <= PC_RESET;
      valid_out <= 1'b0;
      flush_out <= 1'b0;
    end else begin
      flush_out <= branch_taken;
      if (branch_taken) begin
        insn_out  <= INSN_W'(NOP_INSN);
        valid_out <= 1'b0;
      end else if (!stall) begin
        if (buf_full) begin
          insn_out  <= buf_insn;
          pc_out    <= buf_pc;
          valid_out <= 1'b1;
        end else if (load_direct) begin
          insn_out  <= imem_rdata;
          pc_out    <= imem_addr;
          valid_out <= 1'b1;
        end else begin
          // ID consumed the previous instruction and nothing replaces it.
          valid_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] PC0 = 32'h80020000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] insn_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        flush_out;

  always #5 clock = ~clock;

  fetch_unit #(
    .ADDR_W   (32),
    .INSN_W   (32),
    .PC_RESET (32'h80020000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .insn_out      (insn_out),
    .pc_out        (pc_out),
    .valid_out     (valid_out),
    .flush_out     (flush_out)
  );

  int          checks = 0;
  int          errors = 0;
  int          fixed_delay = 0;
  int          cur_delay = 0;
  int          wcnt = 0;
  int          consumed = 0;
  logic        force_ready = 1'b0;
  logic [31:0] exp_pc = PC0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h11110000 + a;
  endfunction

  function automatic int pick_delay();
    if (fixed_delay >= 0) return fixed_delay;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One reset edge; reference model restarts at the reset PC.
  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    imem_ready = 1'b0;
    force_ready = 1'b0;
    @(posedge clock);
    #1;
    exp_pc = PC0;
    wcnt = 0;
    cur_delay = pick_delay();
    reset = 1'b0;
  endtask

  // One clock: memory answers the current request, the model checks what ID
  // consumes this cycle, and bus/flush rules are checked after the edge.
  task automatic cycle();
    logic        p_req;
    logic        p_ready;
    logic        p_br;
    logic [31:0] p_addr;
    if (force_ready) begin
      imem_ready = 1'b1;
      imem_rdata = 32'hDEADBEEF;
    end else if (imem_req && wcnt >= cur_delay) begin
      imem_ready = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end else begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
    end
    p_req   = imem_req;
    p_ready = imem_ready;
    p_addr  = imem_addr;
    p_br    = branch_taken;
    if (valid_out && !stall && !branch_taken) begin
      chk("consume_pc", pc_out, exp_pc);
      chk("consume_insn", insn_out, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (branch_taken) exp_pc = {branch_target[31:2], 2'b00};
    @(posedge clock);
    #1;
    chk1("flush_pulse", flush_out, p_br);
    if (p_req && !p_ready) begin
      chk1("req_held", imem_req, 1'b1);
      chk("addr_held", imem_addr, p_addr);
    end
    if (p_req && p_ready) begin
      wcnt = 0;
      cur_delay = pick_delay();
    end else if (p_req) begin
      wcnt++;
    end
  endtask

  initial begin
    int c0;

    // Reset state and zero-wait streaming
    fixed_delay = 0;
    do_reset();
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_pc_out", pc_out, PC0);
    chk1("rst_valid", valid_out, 1'b0);
    chk1("rst_flush", flush_out, 1'b0);
    chk("rst_insn", insn_out, 32'h0);
    cycle();
    chk1("t1_valid_first", valid_out, 1'b0);
    chk1("t1_req", imem_req, 1'b1);
    chk("t1_addr", imem_addr, PC0);
    cycle();
    chk1("t1_valid", valid_out, 1'b1);
    chk("t1_pc0", pc_out, PC0);
    chk("t1_insn0", insn_out, 32'h91130000);
    cycle();
    chk("t1_pc1", pc_out, PC0 + 32'd4);
    cycle();
    chk("t1_pc2", pc_out, PC0 + 32'd8);

    // Memory delays the second request by 3 cycles
    fixed_delay = 0;
    do_reset();
    c0 = consumed;
    cycle();
    fixed_delay = 3;
    cycle();
    for (int k = 0; k < 3; k++) begin
      chk1("t2_req_wait", imem_req, 1'b1);
      chk("t2_addr_wait", imem_addr, PC0 + 32'd4);
      cycle();
    end
    cycle();
    chk("t2_pc", pc_out, PC0 + 32'd4);
    chk1("t2_valid", valid_out, 1'b1);
    cycle();
    chk1("t2_bubble", valid_out, 1'b0);
    chk("t2_delivered", 32'(consumed - c0), 32'd2);

    // Stall for 4 cycles while streaming
    fixed_delay = 0;
    do_reset();
    cycle();
    cycle();
    cycle();
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t3_pc_frozen", pc_out, PC0 + 32'd4);
      chk("t3_insn_frozen", insn_out, mem_word(PC0 + 32'd4));
      chk1("t3_req_dropped", imem_req, 1'b0);
    end
    stall = 1'b0;
    cycle();
    chk("t3_buffered_pc", pc_out, PC0 + 32'd8);
    chk1("t3_buffered_valid", valid_out, 1'b1);
    cycle();
    chk("t3_next_pc", pc_out, PC0 + 32'd12);

    // Redirect while a request is pending
    fixed_delay = 2;
    do_reset();
    cycle();
    branch_taken = 1'b1;
    branch_target = 32'h80020103;
    cycle();
    branch_taken = 1'b0;
    chk1("t4_flush", flush_out, 1'b1);
    chk1("t4_valid", valid_out, 1'b0);
    chk("t4_addr_kept", imem_addr, PC0);
    cycle();
    chk1("t4_flush_end", flush_out, 1'b0);
    fixed_delay = 0;
    cycle();
    chk1("t4_stale_dropped", valid_out, 1'b0);
    chk("t4_new_addr", imem_addr, 32'h80020100);
    cycle();
    chk("t4_target_pc", pc_out, 32'h80020100);
    chk1("t4_target_valid", valid_out, 1'b1);
    chk("t4_target_insn", insn_out, mem_word(32'h80020100));

    // Redirect together with stall and a returning response
    fixed_delay = 0;
    do_reset();
    cycle();
    cycle();
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h80020200;
    cycle();
    stall = 1'b0;
    branch_taken = 1'b0;
    chk1("t5_valid", valid_out, 1'b0);
    chk("t5_nop", insn_out, 32'h0);
    chk1("t5_req", imem_req, 1'b1);
    chk("t5_addr", imem_addr, 32'h80020200);
    cycle();
    chk("t5_pc", pc_out, 32'h80020200);
    chk1("t5_valid_after", valid_out, 1'b1);

    // Reset in the middle of a pending request, then a late ready
    fixed_delay = 3;
    do_reset();
    cycle();
    cycle();
    chk1("t6_pending", imem_req, 1'b1);
    fixed_delay = 0;
    do_reset();
    chk1("t6_req", imem_req, 1'b0);
    chk("t6_pc_out", pc_out, PC0);
    chk1("t6_valid", valid_out, 1'b0);
    force_ready = 1'b1;
    cycle();
    force_ready = 1'b0;
    chk1("t6_late_ignored", valid_out, 1'b0);
    chk("t6_addr", imem_addr, PC0);
    cycle();
    chk("t6_first_pc", pc_out, PC0);
    chk("t6_first_insn", insn_out, mem_word(PC0));

    // Randomized traffic against the reference model
    fixed_delay = -1;
    do_reset();
    c0 = consumed;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 19) == 0);
      branch_target = PC0 + $urandom_range(0, 4095);
      cycle();
    end
    stall = 1'b0;
    branch_taken = 1'b0;
    chk1("rand_progress", (consumed - c0) >= 200, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
